// File: rtl/ysyx_22050598_axi_arbiter_pkg.sv
// Shared definitions for the AXI arbiter: FSM encodings, AXI constants and the
// grant-index width helper.
package ysyx_22050598_defines;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BURST = 2'd1,
    W_RESP  = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Width of a master index; never narrower than one bit.
  function automatic int gnt_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_22050598_axi_arbiter_if.sv
// AXI4 bus bundle with N concatenated lanes (lane i at [i*W +: W]); N=1 is a
// plain single AXI port. cache/prot/qos only exist on the master side.
interface ysyx_22050598_axi_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [N-1:0]        awvalid;
  logic [N-1:0]        awready;
  logic [N*ID_W-1:0]   awid;
  logic [N*ADDR_W-1:0] awaddr;
  logic [N*8-1:0]      awlen;
  logic [N*3-1:0]      awsize;
  logic [N*2-1:0]      awburst;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;

  logic [N-1:0]        wvalid;
  logic [N-1:0]        wready;
  logic [N*DATA_W-1:0] wdata;
  logic [N*STRB_W-1:0] wstrb;
  logic [N-1:0]        wlast;

  logic [N-1:0]        bvalid;
  logic [N-1:0]        bready;
  logic [N*ID_W-1:0]   bid;
  logic [N*2-1:0]      bresp;

  logic [N-1:0]        arvalid;
  logic [N-1:0]        arready;
  logic [N*ID_W-1:0]   arid;
  logic [N*ADDR_W-1:0] araddr;
  logic [N*8-1:0]      arlen;
  logic [N*3-1:0]      arsize;
  logic [N*2-1:0]      arburst;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;

  logic [N-1:0]        rvalid;
  logic [N-1:0]        rready;
  logic [N*ID_W-1:0]   rid;
  logic [N*DATA_W-1:0] rdata;
  logic [N*2-1:0]      rresp;
  logic [N-1:0]        rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/ysyx_22050598_axi_arbiter_rr_arb.sv
// Round-robin request arbiter with one-hot and index grant outputs.
// Defining YSYX_22050598_AXI_ARB_FIXED_PRIO_EN makes it fixed priority (lowest index wins).
module ysyx_22050598_rr_arb
  import ysyx_22050598_defines::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = gnt_idx_w(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req,
  input  logic             upd,
  output logic [NUM_M-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

`ifdef YSYX_22050598_AXI_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = clk ^ rst ^ upd;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (req[k] && !found) begin
        found     = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;

  // Scan starts one past the last winner so that winner gets lowest priority.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (req[cand] && !found) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IDX_W'(cand);
      end
    end
    ptr_d = (upd && found) ? gnt_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IDX_W'(NUM_M - 1);
    else     ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/ysyx_22050598_axi_arbiter.sv
// N-master to 1-slave AXI4 arbiter; read and write channels each hold one
// transaction at a time. YSYX_22050598_AXI_ARB_FIXED_PRIO_EN selects fixed priority.
module ysyx_22050598_axi_arbiter
  import ysyx_22050598_defines::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050598_axi_arbiter_if.slave    s,
  ysyx_22050598_axi_arbiter_if.master   m
);

  localparam int IDX_W  = gnt_idx_w(NUM_M);
  localparam int STRB_W = DATA_W / 8;

  rd_state_e        rd_state_q, rd_state_d;
  wr_state_e        wr_state_q, wr_state_d;
  logic [IDX_W-1:0] rd_gnt_q, rd_gnt_d;
  logic [IDX_W-1:0] wr_gnt_q, wr_gnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             rd_upd, wr_upd;
  logic             aw_fire, wl_fire;
  logic [NUM_M-1:0] ar_oh, aw_oh;
  logic [IDX_W-1:0] ar_idx, aw_idx;
  logic [NUM_M-1:0] wr_req;

  // A write may open with W ahead of AW, so either channel requests the grant.
  assign wr_req = s.awvalid | s.wvalid;

  ysyx_22050598_rr_arb #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_ar_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (s.arvalid),
    .upd     (rd_upd),
    .gnt_oh  (ar_oh),
    .gnt_idx (ar_idx)
  );

  ysyx_22050598_rr_arb #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_aw_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .upd     (wr_upd),
    .gnt_oh  (aw_oh),
    .gnt_idx (aw_idx)
  );

  assign m.awcache = '0;
  assign m.awprot  = '0;
  assign m.awqos   = '0;
  assign m.arcache = '0;
  assign m.arprot  = '0;
  assign m.arqos   = '0;

  // Response payloads go to every lane; only the owner sees valid.
  assign s.rid   = {NUM_M{m.rid}};
  assign s.rdata = {NUM_M{m.rdata}};
  assign s.rresp = {NUM_M{m.rresp}};
  assign s.rlast = {NUM_M{m.rlast}};
  assign s.bid   = {NUM_M{m.bid}};
  assign s.bresp = {NUM_M{m.bresp}};

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_upd     = 1'b0;
    m.arvalid  = 1'b0;
    m.arid     = s.arid[rd_gnt_q*ID_W +: ID_W];
    m.araddr   = s.araddr[rd_gnt_q*ADDR_W +: ADDR_W];
    m.arlen    = s.arlen[rd_gnt_q*8 +: 8];
    m.arsize   = s.arsize[rd_gnt_q*3 +: 3];
    m.arburst  = s.arburst[rd_gnt_q*2 +: 2];
    s.arready  = '0;
    s.rvalid   = '0;
    m.rready   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (|ar_oh) begin
          rd_gnt_d   = ar_idx;
          rd_upd     = 1'b1;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m.arvalid           = s.arvalid[rd_gnt_q];
        s.arready[rd_gnt_q] = m.arready;
        if (m.arvalid && m.arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s.rvalid[rd_gnt_q] = m.rvalid;
        m.rready           = s.rready[rd_gnt_q];
        if (m.rvalid && m.rready && m.rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_upd     = 1'b0;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_fire    = 1'b0;
    wl_fire    = 1'b0;
    m.awvalid  = 1'b0;
    m.awid     = s.awid[wr_gnt_q*ID_W +: ID_W];
    m.awaddr   = s.awaddr[wr_gnt_q*ADDR_W +: ADDR_W];
    m.awlen    = s.awlen[wr_gnt_q*8 +: 8];
    m.awsize   = s.awsize[wr_gnt_q*3 +: 3];
    m.awburst  = s.awburst[wr_gnt_q*2 +: 2];
    m.wvalid   = 1'b0;
    m.wdata    = s.wdata[wr_gnt_q*DATA_W +: DATA_W];
    m.wstrb    = s.wstrb[wr_gnt_q*STRB_W +: STRB_W];
    m.wlast    = s.wlast[wr_gnt_q];
    s.awready  = '0;
    s.wready   = '0;
    s.bvalid   = '0;
    m.bready   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (|aw_oh) begin
          wr_gnt_d   = aw_idx;
          wr_upd     = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_BURST;
        end
      end
      W_BURST: begin
        // Each half is masked once done so a finished AW or W is not reissued.
        m.awvalid           = s.awvalid[wr_gnt_q] & ~aw_done_q;
        s.awready[wr_gnt_q] = m.awready & ~aw_done_q;
        m.wvalid            = s.wvalid[wr_gnt_q] & ~w_done_q;
        s.wready[wr_gnt_q]  = m.wready & ~w_done_q;
        aw_fire             = m.awvalid & m.awready;
        wl_fire             = m.wvalid & m.wready & m.wlast;
        if (aw_fire) aw_done_d = 1'b1;
        if (wl_fire) w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || wl_fire)) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s.bvalid[wr_gnt_q] = m.bvalid;
        m.bready           = s.bready[wr_gnt_q];
        if (m.bvalid && m.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule
